// File: rtl/axi_wr_traffic_gen.sv
// axi_wr_traffic_gen: AXI4 write traffic generator for DDR self-test (init fill, single commands, 4 data patterns, B error count)
// Ports: clk, rst_n (sync, active low); init_start/write_en/cmd_*/pattern_mode/random_data_en from the sequencer;
// write_done_p/init_done/busy/bresp_err_cnt/outstanding status; full AXI4 AW/W/B master channels.
// Optional macro TG_ERR_INJECT_EN adds inject_err, a one-shot that flips wdata[0] of the next accepted W beat.
module axi_wr_traffic_gen #(
  parameter int AXI_DATA_WIDTH  = 128,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int ID_WIDTH        = 8,
  parameter int MEM_SPACE_AW    = 18,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef TG_ERR_INJECT_EN
  input  logic                        inject_err,
`endif
  input  logic                        init_start,
  input  logic                        write_en,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [ID_WIDTH-1:0]         cmd_id,
  input  logic [7:0]                  cmd_len,
  input  logic [1:0]                  pattern_mode,
  input  logic                        random_data_en,
  output logic                        write_done_p,
  output logic                        init_done,
  output logic                        busy,
  output logic [15:0]                 bresp_err_cnt,
  output logic [4:0]                  outstanding,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [ID_WIDTH-1:0]         axi_awid,
  output logic [7:0]                  axi_awlen,
  output logic [2:0]                  axi_awsize,
  output logic [1:0]                  axi_awburst,
  output logic                        axi_awvalid,
  input  logic                        axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                        axi_wvalid,
  output logic                        axi_wlast,
  input  logic                        axi_wready,
  input  logic [ID_WIDTH-1:0]         axi_bid,
  input  logic [1:0]                  axi_bresp,
  input  logic                        axi_bvalid,
  output logic                        axi_bready
);
  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int NL = AXI_DATA_WIDTH / 16;
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES = AXI_ADDR_WIDTH'(16 * BYTES);
  localparam logic [AXI_ADDR_WIDTH:0] SPACE = (AXI_ADDR_WIDTH+1)'(1) << (MEM_SPACE_AW + 2);
  localparam logic [4:0] MO = 5'(MAX_OUTSTANDING);
  typedef enum logic [2:0] {IDLE, INIT, INIT_WAIT, CMD, ABORT} state_t;
  state_t state, state_nx;
  logic [AXI_ADDR_WIDTH-1:0] q_addr [MAX_OUTSTANDING];
  logic [7:0] q_len [MAX_OUTSTANDING];
  logic [PW-1:0] wp, rp;
  logic [4:0] q_cnt;
  logic [7:0] beat;
  logic [31:0] lfsr;
  logic [AXI_ADDR_WIDTH-1:0] ba;
  logic [AXI_DATA_WIDTH-1:0] lanes, data;
  logic [7:0] r;
  logic aw_hs, w_hs, b_hs, q_empty, q_full, drained, last_burst;
  logic unused_ok;
  assign axi_awsize = 3'($clog2(BYTES));
  assign axi_awburst = 2'b01;
  assign axi_wstrb = '1;
  assign axi_bready = 1'b1;
  assign q_empty = q_cnt == 5'd0;
  assign q_full = q_cnt == MO;
  assign drained = outstanding == 5'd0 && q_empty;
  // In INIT the request is withheld while the outstanding window is full; once raised it
  // cannot drop because outstanding only shrinks until this AW is accepted.
  assign axi_awvalid = state == CMD || (state == INIT && outstanding < MO && !q_full);
  assign aw_hs = axi_awvalid && axi_awready;
  assign axi_wvalid = !q_empty;
  assign axi_wlast = axi_wvalid && beat == q_len[rp];
  assign w_hs = axi_wvalid && axi_wready;
  assign b_hs = axi_bvalid;
  assign write_done_p = state == CMD && aw_hs;
  assign busy = axi_awvalid || !q_empty || outstanding != 5'd0;
  assign last_burst = ({1'b0, axi_awaddr} + {1'b0, BURST_BYTES}) == SPACE;
  assign ba = q_addr[rp] + AXI_ADDR_WIDTH'(beat) * AXI_ADDR_WIDTH'(BYTES);
  assign unused_ok = ^{axi_bid, ba[AXI_ADDR_WIDTH-1:11], ba[2:0]};
  always_comb begin
    r = 8'h00;
    lanes = '0;
    for (int k = 0; k < NL; k++) begin
      r = random_data_en ? lfsr[8*(k%4)+:8] : 8'h00;
      lanes[16*k+:16] = pattern_mode == 2'd1 ? ((k % 2 == 0) ? 16'hFFFF : 16'h0000) : {r, r ^ (ba[10:3] + 8'(k))};
    end
    data = pattern_mode[1] ? (pattern_mode[0] ? '0 : AXI_DATA_WIDTH'(1) << (32'(beat) % AXI_DATA_WIDTH)) : lanes;
  end
`ifdef TG_ERR_INJECT_EN
  logic inj_arm;
  always_ff @(posedge clk) begin
    if (!rst_n) inj_arm <= 1'b0;
    else if (w_hs && inj_arm) inj_arm <= 1'b0;
    else if (inject_err) inj_arm <= 1'b1;
  end
  assign axi_wdata = data ^ AXI_DATA_WIDTH'(inj_arm);
`else
  assign axi_wdata = data;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // Dropping init_start mid-fill lets the in-flight AW finish, then drains without setting init_done.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = (init_start && !init_done) ? INIT :
                       (!init_start && write_en && outstanding < MO && !q_full) ? CMD : IDLE;
      INIT: state_nx = (aw_hs && last_burst) ? (init_start ? INIT_WAIT : ABORT) :
                       (!init_start && (aw_hs || !axi_awvalid)) ? ABORT : INIT;
      INIT_WAIT: state_nx = drained ? IDLE : INIT_WAIT;
      CMD: state_nx = aw_hs ? IDLE : CMD;
      ABORT: state_nx = drained ? IDLE : ABORT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) init_done <= 1'b0;
    else if (!init_start) init_done <= 1'b0;
    else if (state == INIT_WAIT && drained) init_done <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      q_addr[wp] <= axi_awaddr;
      q_len[wp] <= axi_awlen;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      axi_awaddr <= '0;
      axi_awid <= '0;
      axi_awlen <= '0;
      outstanding <= '0;
      wp <= '0;
      rp <= '0;
      q_cnt <= '0;
      beat <= '0;
      lfsr <= 32'h0707_336A;
      bresp_err_cnt <= '0;
    end else begin
      if (state == IDLE && state_nx == INIT) begin
        axi_awaddr <= '0;
        axi_awid <= '0;
        axi_awlen <= 8'd15;
      end else if (state == IDLE && state_nx == CMD) begin
        axi_awaddr <= cmd_addr;
        axi_awid <= cmd_id;
        axi_awlen <= cmd_len;
      end else if (state == INIT && aw_hs) begin
        axi_awaddr <= axi_awaddr + BURST_BYTES;
        axi_awid <= axi_awid + ID_WIDTH'(1);
      end
      if (aw_hs && !b_hs) outstanding <= outstanding + 5'd1;
      else if (!aw_hs && b_hs && outstanding != 5'd0) outstanding <= outstanding - 5'd1;
      if (aw_hs) wp <= (wp == PW'(MAX_OUTSTANDING - 1)) ? '0 : wp + PW'(1);
      if (w_hs) begin
        lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
        beat <= axi_wlast ? 8'd0 : beat + 8'd1;
        if (axi_wlast) rp <= (rp == PW'(MAX_OUTSTANDING - 1)) ? '0 : rp + PW'(1);
      end
      q_cnt <= q_cnt + {4'd0, aw_hs} - {4'd0, w_hs && axi_wlast};
      if (b_hs && axi_bresp != 2'b00 && bresp_err_cnt != 16'hFFFF) bresp_err_cnt <= bresp_err_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_axi_wr_traffic_gen.sv
// tb_axi_wr_traffic_gen: directed table-driven bench for axi_wr_traffic_gen (128-bit, 16 KiB init space, 4 outstanding)
module tb_axi_wr_traffic_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, init_start, write_en, random_data_en, inject_err;
  logic [31:0] cmd_addr;
  logic [7:0] cmd_id, cmd_len;
  logic [1:0] pattern_mode;
  logic write_done_p, init_done, busy;
  logic [15:0] bresp_err_cnt;
  logic [4:0] outstanding;
  logic [31:0] axi_awaddr;
  logic [7:0] axi_awid, axi_awlen;
  logic [2:0] axi_awsize;
  logic [1:0] axi_awburst;
  logic axi_awvalid, axi_awready;
  logic [127:0] axi_wdata;
  logic [15:0] axi_wstrb;
  logic axi_wvalid, axi_wlast, axi_wready;
  logic [7:0] axi_bid;
  logic [1:0] axi_bresp;
  logic axi_bvalid, axi_bready;
  axi_wr_traffic_gen #(.AXI_DATA_WIDTH(128), .AXI_ADDR_WIDTH(32), .ID_WIDTH(8), .MEM_SPACE_AW(12), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef TG_ERR_INJECT_EN
    .inject_err(inject_err),
`endif
    .init_start(init_start), .write_en(write_en), .cmd_addr(cmd_addr), .cmd_id(cmd_id), .cmd_len(cmd_len),
    .pattern_mode(pattern_mode), .random_data_en(random_data_en), .write_done_p(write_done_p), .init_done(init_done),
    .busy(busy), .bresp_err_cnt(bresp_err_cnt), .outstanding(outstanding), .axi_awaddr(axi_awaddr), .axi_awid(axi_awid),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wlast(axi_wlast),
    .axi_wready(axi_wready), .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready));
  typedef struct { logic [127:0] data; logic last; logic [31:0] lf; } wbeat_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; logic [7:0] id; } aw_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; logic [1:0] mode; logic [127:0] first; logic [127:0] last; } vec_t;
  wbeat_t wq[$];
  aw_t awq[$];
  int b_cnt, wd_cnt, pend, err_done, err_req, total, bad;
  logic b_en;
  logic [31:0] tb_lfsr;
  always @(posedge clk) begin
    if (!rst_n) begin
      tb_lfsr = 32'h0707_336A;
      pend = 0;
    end else begin
      if (axi_awvalid && axi_awready) awq.push_back('{axi_awaddr, axi_awlen, axi_awid});
      if (write_done_p) wd_cnt++;
      if (axi_wvalid && axi_wready) begin
        wq.push_back('{axi_wdata, axi_wlast, tb_lfsr});
        tb_lfsr = {tb_lfsr[30:0], tb_lfsr[31] ^ tb_lfsr[21] ^ tb_lfsr[1] ^ tb_lfsr[0]};
        if (axi_wlast) pend++;
      end
      if (axi_bvalid && axi_bready) begin
        b_cnt++;
        pend--;
        if (axi_bresp != 2'b00) err_done++;
      end
    end
  end
  always @(negedge clk) begin
    axi_bvalid = b_en && pend > 0;
    axi_bresp = (err_done < err_req) ? 2'b10 : 2'b00;
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic wait_idle(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < bound);
    if (busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles", bound);
    end
  endtask
  task automatic run_cmd(input logic [31:0] a, input logic [7:0] l, input logic [7:0] id, input logic [1:0] m);
    @(negedge clk);
    cmd_addr = a;
    cmd_len = l;
    cmd_id = id;
    pattern_mode = m;
    write_en = 1'b1;
    @(posedge clk);
    #1 write_en = 1'b0;
  endtask
  function automatic logic [127:0] m0(input logic [31:0] a, input logic [31:0] l);
    logic [127:0] d;
    logic [7:0] rb;
    d = '0;
    for (int k = 0; k < 8; k++) begin
      rb = l[8*(k%4)+:8];
      d[16*k+:16] = {rb, rb ^ (a[10:3] + 8'(k))};
    end
    return d;
  endfunction
  vec_t tv[5];
  initial begin
    int sa, sw, sd, sb, nl, hb, n;
    rst_n = 1'b0; init_start = 1'b0; write_en = 1'b0; random_data_en = 1'b0; inject_err = 1'b0;
    cmd_addr = '0; cmd_id = '0; cmd_len = '0; pattern_mode = '0; axi_bid = '0;
    axi_awready = 1'b1; axi_wready = 1'b1; b_en = 1'b1; err_req = 0;
    tv[0] = '{32'h40, 8'd3, 2'd0, 128'h000F_000E_000D_000C_000B_000A_0009_0008, 128'h0015_0014_0013_0012_0011_0010_000F_000E};
    tv[1] = '{32'h1000, 8'd0, 2'd1, {4{32'h0000_FFFF}}, {4{32'h0000_FFFF}}};
    tv[2] = '{32'h200, 8'd1, 2'd2, 128'h1, 128'h2};
    tv[3] = '{32'h0, 8'd7, 2'd3, 128'h0, 128'h0};
    tv[4] = '{32'h7F0, 8'd2, 2'd0, 128'h0005_0004_0003_0002_0001_0000_00FF_00FE, 128'h0009_0008_0007_0006_0005_0004_0003_0002};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_awvalid", 128'(axi_awvalid), 128'(0));
    chk("rst_wvalid", 128'(axi_wvalid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_outstanding", 128'(outstanding), 128'(0));
    chk("rst_init_done", 128'(init_done), 128'(0));
    chk("rst_errcnt", 128'(bresp_err_cnt), 128'(0));
    chk("rst_awaddr", 128'(axi_awaddr), 128'(0));
    chk("const_bready", 128'(axi_bready), 128'(1));
    chk("const_awsize", 128'(axi_awsize), 128'(4));
    chk("const_awburst", 128'(axi_awburst), 128'(1));
    chk("const_wstrb", 128'(axi_wstrb), 128'(16'hFFFF));
    for (int i = 0; i < 5; i++) begin
      sa = awq.size(); sw = wq.size(); sd = wd_cnt;
      run_cmd(tv[i].addr, tv[i].len, 8'(i + 3), tv[i].mode);
      wait_idle(300);
      chk($sformatf("v%0d_aw_count", i), 128'(awq.size() - sa), 128'(1));
      chk($sformatf("v%0d_done_pulses", i), 128'(wd_cnt - sd), 128'(1));
      chk($sformatf("v%0d_beats", i), 128'(wq.size() - sw), 128'(int'(tv[i].len) + 1));
      if (awq.size() > sa) begin
        chk($sformatf("v%0d_awaddr", i), 128'(awq[sa].addr), 128'(tv[i].addr));
        chk($sformatf("v%0d_awlen", i), 128'(awq[sa].len), 128'(tv[i].len));
        chk($sformatf("v%0d_awid", i), 128'(awq[sa].id), 128'(i + 3));
      end
      if (wq.size() > sw) begin
        nl = 0;
        for (int j = sw; j < wq.size(); j++) nl += int'(wq[j].last);
        chk($sformatf("v%0d_first_data", i), wq[sw].data, tv[i].first);
        chk($sformatf("v%0d_last_data", i), wq[wq.size()-1].data, tv[i].last);
        chk($sformatf("v%0d_wlast_on_final", i), 128'(wq[wq.size()-1].last), 128'(1));
        chk($sformatf("v%0d_wlast_count", i), 128'(nl), 128'(1));
      end
    end
    sw = wq.size();
    random_data_en = 1'b1;
    run_cmd(32'h100, 8'd1, 8'h11, 2'd0);
    wait_idle(300);
    random_data_en = 1'b0;
    chk("rnd_beats", 128'(wq.size() - sw), 128'(2));
    for (int j = sw; j < wq.size(); j++) chk($sformatf("rnd_beat%0d", j - sw), wq[j].data, m0(32'h100 + 32'(16 * (j - sw)), wq[j].lf));
    sa = awq.size();
    b_en = 1'b0;
    @(negedge clk);
    cmd_addr = 32'h0; cmd_len = 8'd0; pattern_mode = 2'd3; write_en = 1'b1;
    repeat (40) @(negedge clk);
    chk("lim_aw_count", 128'(awq.size() - sa), 128'(4));
    chk("lim_outstanding", 128'(outstanding), 128'(4));
    chk("lim_awvalid", 128'(axi_awvalid), 128'(0));
    chk("lim_busy", 128'(busy), 128'(1));
    b_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("lim_resumed", 128'(awq.size() - sa >= 5), 128'(1));
    write_en = 1'b0;
    wait_idle(300);
    chk("lim_drained", 128'(outstanding), 128'(0));
    axi_awready = 1'b0;
    axi_wready = 1'b0;
    run_cmd(32'h300, 8'd1, 8'h22, 2'd2);
    hb = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!axi_awvalid || axi_awaddr !== 32'h300 || axi_awlen !== 8'd1 || axi_wvalid) hb++;
    end
    chk("aw_hold_stable", 128'(hb), 128'(0));
    axi_awready = 1'b1;
    @(negedge clk);
    chk("w_after_aw", 128'(axi_wvalid), 128'(1));
    hb = 0;
    for (int c = 0; c < 5; c++) begin
      if (!axi_wvalid || axi_wdata !== 128'h1 || axi_wlast) hb++;
      @(negedge clk);
    end
    chk("w_hold_beat0", 128'(hb), 128'(0));
    axi_wready = 1'b1;
    @(negedge clk);
    axi_wready = 1'b0;
    hb = 0;
    for (int c = 0; c < 3; c++) begin
      if (!axi_wvalid || axi_wdata !== 128'h2 || !axi_wlast) hb++;
      @(negedge clk);
    end
    chk("w_hold_beat1", 128'(hb), 128'(0));
    axi_wready = 1'b1;
    wait_idle(300);
    err_req = err_done + 3;
    sw = wq.size();
    for (int i = 0; i < 3; i++) begin
      run_cmd(32'h2000 + 32'(i * 16), 8'd0, 8'(i), 2'd1);
      wait_idle(300);
    end
    chk("bresp_err_cnt", 128'(bresp_err_cnt), 128'(3));
    if (wq.size() > sw) chk("mode1_data", wq[sw].data, {4{32'h0000_FFFF}});
    sa = awq.size(); sw = wq.size(); sb = b_cnt;
    init_start = 1'b1;
    n = 0;
    while (!init_done && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("init_done_set", 128'(init_done), 128'(1));
    chk("init_b_before_done", 128'(b_cnt - sb), 128'(64));
    chk("init_aw_count", 128'(awq.size() - sa), 128'(64));
    chk("init_w_beats", 128'(wq.size() - sw), 128'(1024));
    hb = 0;
    for (int j = sa; j < awq.size(); j++)
      if (awq[j].addr !== 32'((j - sa) * 256) || awq[j].len !== 8'd15 || awq[j].id !== 8'(j - sa)) hb++;
    chk("init_aw_sequence", 128'(hb), 128'(0));
    chk("init_outstanding", 128'(outstanding), 128'(0));
    chk("init_busy", 128'(busy), 128'(0));
    @(negedge clk);
    chk("init_done_sticky", 128'(init_done), 128'(1));
    init_start = 1'b0;
    @(negedge clk);
    chk("init_done_clear", 128'(init_done), 128'(0));
    sa = awq.size();
    init_start = 1'b1;
    repeat (6) @(negedge clk);
    init_start = 1'b0;
    wait_idle(500);
    chk("abort_no_done", 128'(init_done), 128'(0));
    chk("abort_partial", 128'(awq.size() - sa < 64), 128'(1));
    sa = awq.size();
    run_cmd(32'h500, 8'd0, 8'h33, 2'd3);
    wait_idle(300);
    chk("abort_then_cmd", 128'(awq.size() - sa), 128'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
